// File: rtl/uart_rx.sv
// uart_rx: 8N1 serial receiver.
// The RX line is synchronized through two flops. The start bit is validated
// at mid-bit, and the data bits are sampled at bit centres, LSB first.
// A good stop bit pulses o_Rx_DV. A low stop bit pulses o_Frame_Err, and the
// FSM then parks in BREAK until the line returns high.
module uart_rx #(
  parameter int unsigned CLKS_PER_BIT = 868
) (
  input  logic       i_Clk,
  input  logic       i_Rst_n,
  input  logic       i_Rx_Serial,
  output logic [7:0] o_Rx_Byte,
  output logic       o_Rx_DV,
  output logic       o_Frame_Err,
  output logic       o_Busy
);

  localparam int unsigned CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] HALF = CW'((CLKS_PER_BIT - 1) / 2);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_BREAK
  } state_e;

  logic          sync1_q;
  logic          sync2_q;
  state_e        state_q;
  logic [CW-1:0] cnt_q;
  logic [2:0]    idx_q;
  logic [7:0]    shift_q;
  logic [7:0]    byte_q;
  logic          dv_q;
  logic          fe_q;
  logic          busy_q;

  // Two-flop synchronizer for the asynchronous RX line; it idles high.
  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      sync1_q <= i_Rx_Serial;
      sync2_q <= sync1_q;
    end
  end

  // Receive FSM with registered byte, strobe and busy outputs.
  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      byte_q  <= '0;
      dv_q    <= 1'b0;
      fe_q    <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      dv_q <= 1'b0;
      fe_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (!sync2_q) begin
            state_q <= S_START;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
          end
        end
        S_START: begin
          if (cnt_q != HALF) begin
            cnt_q <= cnt_q + 1'b1;
          end else if (!sync2_q) begin
            state_q <= S_DATA;
            cnt_q   <= '0;
            idx_q   <= '0;
          end else begin
            // The line came back high before mid-bit, so this was a glitch.
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end
        end
        S_DATA: begin
          if (cnt_q != LAST) begin
            cnt_q <= cnt_q + 1'b1;
          end else begin
            cnt_q          <= '0;
            shift_q[idx_q] <= sync2_q;
            if (idx_q == 3'd7) begin
              state_q <= S_STOP;
            end else begin
              idx_q <= idx_q + 1'b1;
            end
          end
        end
        S_STOP: begin
          if (cnt_q != LAST) begin
            cnt_q <= cnt_q + 1'b1;
          end else begin
            cnt_q <= '0;
            if (sync2_q) begin
              // Return at stop-bit centre so back-to-back starts are caught.
              byte_q  <= shift_q;
              dv_q    <= 1'b1;
              state_q <= S_IDLE;
              busy_q  <= 1'b0;
            end else begin
              fe_q    <= 1'b1;
              state_q <= S_BREAK;
            end
          end
        end
        S_BREAK: begin
          if (sync2_q) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign o_Rx_Byte   = byte_q;
  assign o_Rx_DV     = dv_q;
  assign o_Frame_Err = fe_q;
  assign o_Busy      = busy_q;

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed-vector bench for uart_rx with CLKS_PER_BIT = 16.
module tb_uart_rx;

  localparam int unsigned CPB = 16;

  logic       clk;
  logic       rst_n;
  logic       rx;
  logic [7:0] rx_byte;
  logic       rx_dv;
  logic       frame_err;
  logic       busy;

  uart_rx #(.CLKS_PER_BIT(CPB)) dut (
    .i_Clk      (clk),
    .i_Rst_n    (rst_n),
    .i_Rx_Serial(rx),
    .o_Rx_Byte  (rx_byte),
    .o_Rx_DV    (rx_dv),
    .o_Frame_Err(frame_err),
    .o_Busy     (busy)
  );

  int n_checks = 0;
  int n_fail   = 0;

  int         edge_cnt = 0;
  int         last_start = 0;
  int         dv_edge[$];
  logic [7:0] dv_byte[$];
  int         fe_edge[$];
  int         busy_cnt = 0;
  int         viol = 0;
  logic       prev_strobe = 1'b0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) edge_cnt = edge_cnt + 1;

  // Sample the outputs on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (rx_dv) begin
      dv_edge.push_back(edge_cnt);
      dv_byte.push_back(rx_byte);
    end
    if (frame_err) fe_edge.push_back(edge_cnt);
    if (busy) busy_cnt = busy_cnt + 1;
    if (rx_dv && frame_err) viol = viol + 1;
    if ((rx_dv || frame_err) && prev_strobe) viol = viol + 1;
    prev_strobe = rx_dv || frame_err;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic clear_log();
    dv_edge.delete();
    dv_byte.delete();
    fe_edge.delete();
  endtask

  // Drive one frame, one level per clock on falling edges. A nonzero
  // abort_cyc returns at that cycle without driving it.
  task automatic send_frame(input logic [7:0] b, input logic stop, input int abort_cyc);
    for (int k = 0; k < 10 * CPB; k++) begin
      @(negedge clk);
      if (abort_cyc != 0 && k == abort_cyc) return;
      if (k == 0) last_start = edge_cnt + 1;
      if (k < CPB) rx = 1'b0;
      else if (k < 9 * CPB) rx = b[(k / CPB) - 1];
      else rx = stop;
    end
  endtask

  task automatic idle(input int n);
    @(negedge clk);
    rx = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0;
    rx    = 1'b1;
    #20;
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    check("reset_byte", {24'h0, rx_byte}, 32'h00);
    check("reset_dv", {31'h0, rx_dv}, 32'h0);
    check("reset_fe", {31'h0, frame_err}, 32'h0);
    check("reset_busy", {31'h0, busy}, 32'h0);

    // Single good frame: latency from capturing edge is 154.
    clear_log();
    send_frame(8'hA5, 1'b1, 0);
    idle(20);
    check("a5_dv_count", dv_edge.size(), 1);
    if (dv_edge.size() == 1) begin
      check("a5_latency", dv_edge[0] - last_start, 154);
      check("a5_byte", {24'h0, dv_byte[0]}, 32'hA5);
    end
    check("a5_fe_count", fe_edge.size(), 0);
    check("a5_byte_hold", {24'h0, rx_byte}, 32'hA5);

    // Back-to-back frames, no gap after the stop bit.
    clear_log();
    send_frame(8'h00, 1'b1, 0);
    send_frame(8'hFF, 1'b1, 0);
    send_frame(8'h81, 1'b1, 0);
    idle(20);
    check("b2b_dv_count", dv_edge.size(), 3);
    if (dv_edge.size() == 3) begin
      check("b2b_gap1", dv_edge[1] - dv_edge[0], 160);
      check("b2b_gap2", dv_edge[2] - dv_edge[1], 160);
      check("b2b_byte0", {24'h0, dv_byte[0]}, 32'h00);
      check("b2b_byte1", {24'h0, dv_byte[1]}, 32'hFF);
      check("b2b_byte2", {24'h0, dv_byte[2]}, 32'h81);
    end
    check("b2b_fe_count", fe_edge.size(), 0);

    // Five-cycle glitch: busy from edge 2 up to edge 10 is 8 cycles.
    clear_log();
    busy_cnt = 0;
    @(negedge clk);
    rx = 1'b0;
    repeat (5) @(negedge clk);
    rx = 1'b1;
    repeat (30) @(negedge clk);
    check("glitch_dv", dv_edge.size(), 0);
    check("glitch_fe", fe_edge.size(), 0);
    check("glitch_busy_cycles", busy_cnt, 8);
    check("glitch_busy_le10", {31'h0, busy_cnt <= 10}, 32'h1);
    send_frame(8'h3C, 1'b1, 0);
    idle(20);
    check("post_glitch_dv", dv_edge.size(), 1);
    if (dv_edge.size() == 1) check("post_glitch_byte", {24'h0, dv_byte[0]}, 32'h3C);

    // Good 0xA5, then 0x3C with a low stop bit.
    send_frame(8'hA5, 1'b1, 0);
    idle(10);
    clear_log();
    send_frame(8'h3C, 1'b0, 0);
    idle(20);
    check("ferr_fe_count", fe_edge.size(), 1);
    if (fe_edge.size() == 1) check("ferr_latency", fe_edge[0] - last_start, 154);
    check("ferr_dv_count", dv_edge.size(), 0);
    check("ferr_byte_hold", {24'h0, rx_byte}, 32'hA5);
    check("ferr_busy_after", {31'h0, busy}, 32'h0);

    // Line held low for 40 bit times, then a good 0x5A.
    clear_log();
    @(negedge clk);
    rx = 1'b0;
    last_start = edge_cnt + 1;
    repeat (40 * CPB) @(negedge clk);
    check("break_busy_held", {31'h0, busy}, 32'h1);
    rx = 1'b1;
    repeat (40) @(negedge clk);
    check("break_fe_count", fe_edge.size(), 1);
    if (fe_edge.size() == 1) check("break_fe_latency", fe_edge[0] - last_start, 154);
    check("break_dv_count", dv_edge.size(), 0);
    check("break_busy_after", {31'h0, busy}, 32'h0);
    send_frame(8'h5A, 1'b1, 0);
    idle(20);
    check("break_next_dv", dv_edge.size(), 1);
    if (dv_edge.size() == 1) check("break_next_byte", {24'h0, dv_byte[0]}, 32'h5A);
    check("break_fe_total", fe_edge.size(), 1);

    // Reset just after data-bit-3 centre of 0xC3 (edge 74).
    clear_log();
    send_frame(8'hC3, 1'b1, 75);
    rst_n = 1'b0;
    rx    = 1'b1;
    #1;
    check("rst_byte", {24'h0, rx_byte}, 32'h00);
    check("rst_dv", {31'h0, rx_dv}, 32'h0);
    check("rst_fe", {31'h0, frame_err}, 32'h0);
    check("rst_busy", {31'h0, busy}, 32'h0);
    #29;
    rst_n = 1'b1;
    repeat (200) @(negedge clk);
    check("rst_no_dv", dv_edge.size(), 0);
    check("rst_no_fe", fe_edge.size(), 0);
    send_frame(8'h7E, 1'b1, 0);
    idle(20);
    check("rst_next_dv", dv_edge.size(), 1);
    if (dv_edge.size() == 1) check("rst_next_byte", {24'h0, dv_byte[0]}, 32'h7E);

    check("strobe_rules", viol, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
# uart_rx

Receive-side UART companion to the debounced transmit path: recovers 8N1 serial frames from an asynchronous line into parallel bytes. It synchronizes the raw RX pin, validates the start bit at mid-bit, and samples eight data bits LSB-first at bit centres. It checks the stop bit and emits a one-cycle data-valid or framing-error strobe. It sits between the board RX pin and the byte consumer (loopback to tx, LED display, or FIFO).

## Interface
- CLKS_PER_BIT, default 868, i_Clk cycles per bit (100 MHz / 115200); legal range ≥ 4
- i_Clk  input  1  system clock, rising edge
- i_Rst_n  input  1  reset; asynchronous, active-low
- i_Rx_Serial  input  1  raw serial line, idle high, asynchronous to i_Clk
- o_Rx_Byte  output  8  last correctly framed byte; holds until next good frame
- o_Rx_DV  output  1  one-cycle strobe: o_Rx_Byte updated this cycle
- o_Frame_Err  output  1  one-cycle strobe: stop bit sampled low
- o_Busy  output  1  high while FSM is not IDLE

## Operation
- Synchronizer: two flops, both reset to 1; FSM uses only the second flop output (rx_s).
- Counters:
  - HALF = (CLKS_PER_BIT-1)/2, integer division.
  - Bit counter width $clog2(CLKS_PER_BIT).
  - Bit index is 3 bits.
- States and transitions:
  - IDLE: when rx_s==0, go to START with counter=0.
  - START:
    - While counter!=HALF, increment counter.
    - At HALF, if rx_s==0, go to DATA with counter=0 and index=0.
    - At HALF, if rx_s==1, treat as a glitch and return to IDLE with no strobe.
  - DATA:
    - While counter!=CLKS_PER_BIT-1, increment counter.
    - At terminal count, shift rx_s into shift[index] and clear counter.
    - If index==7, go to STOP; otherwise increment index.
  - STOP:
    - At terminal count, if rx_s==1, load o_Rx_Byte from the shift register, pulse o_Rx_DV, and go to IDLE.
    - At terminal count, if rx_s==0, pulse o_Frame_Err, leave o_Rx_Byte unchanged, and go to BREAK.
  - BREAK: stay until rx_s==1, then go to IDLE. A held-low line therefore yields exactly one error and no false start.
- Back-to-back frames:
  - Return to IDLE happens at stop-bit centre, so a start edge arriving half a bit later is caught.
  - No idle gap is required beyond the stop bit.
- o_Rx_DV and o_Frame_Err are mutually exclusive and never high for two consecutive cycles.
- Reset mid-frame:
  - Asynchronously forces IDLE and clears counter, index and shift register.
  - On release, the partial frame is discarded. If the line is low at release, a new START is entered and validated normally.

## Timing
- Reset values:
  - o_Rx_Byte = 8'h00, o_Rx_DV = 0, o_Frame_Err = 0, o_Busy = 0.
  - State = IDLE; synchronizer flops = 1.
- Edge 0 is the first i_Clk rising edge that captures i_Rx_Serial low in sync flop 1.
  - rx_s is low after edge 1.
  - START is entered at edge 2.
  - Start-bit check occurs at edge 3+HALF.
  - Data bit i is sampled at edge 3+HALF+(i+1)·CLKS_PER_BIT, for i = 0..7.
  - Stop-bit check occurs at edge E = 3+HALF+9·CLKS_PER_BIT.
  - o_Rx_DV or o_Frame_Err is high for exactly the cycle following edge E.
- With CLKS_PER_BIT=16: HALF=7, E=154.
- o_Busy rises at edge 2 and falls at edge E; it stays high through BREAK.
- All outputs are registered; there are no combinational paths from i_Rx_Serial.

## Test plan
- CLKS_PER_BIT=16, 100 MHz clock, reset low 20 ns. Send 0xA5 (start, 1,0,1,0,0,1,0,1, stop 1) → exactly one o_Rx_DV pulse 154 edges after the capturing edge, o_Rx_Byte=8'hA5, o_Frame_Err never high.
- Back-to-back 0x00, 0xFF, 0x81 with no idle between stop and next start → three o_Rx_DV pulses exactly 160 cycles apart, bytes 00, FF, 81 in order.
- Line pulled low for 5 cycles, then high (glitch < HALF) → FSM returns to IDLE, no o_Rx_DV, no o_Frame_Err, o_Busy high for ≤ 10 cycles. Next frame 0x3C is received correctly.
- Frame with data 0x3C and stop bit 0 after a good 0xA5 → one o_Frame_Err pulse, o_Rx_DV stays 0, o_Rx_Byte stays 8'hA5.
- Line held low 40 bit times then released, followed by a frame 0x5A → exactly one o_Frame_Err, then o_Rx_DV with 8'h5A.
- i_Rst_n asserted at the data-bit-3 centre of a 0xC3 frame, released 30 ns later with line high → all outputs at reset values immediately, no strobe for the aborted frame. Next frame 0x7E is received as 8'h7E.
